// File: rtl/hazard_stall_controller_if.sv
// Bundle between the ID-stage pipeline logic and the hazard/stall controller.
// The pipeline side (master) drives hazard information; the controller (slave) returns controls.
interface hazard_stall_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_uses_rs;
  logic              if_id_uses_rt;
  logic              if_id_branch;
  logic              branch_taken;
  logic [REG_AW-1:0] id_ex_reg_dst;
  logic              id_ex_reg_write;
  logic              id_ex_mem_read;
  logic [REG_AW-1:0] ex_mem_reg_dst;
  logic              ex_mem_mem_read;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic              pipe_freeze;
  logic              stall_active;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  freeze_count;

  modport master (
    output if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, if_id_branch, branch_taken,
           id_ex_reg_dst, id_ex_reg_write, id_ex_mem_read, ex_mem_reg_dst, ex_mem_mem_read,
           mem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, stall_active,
           stall_count, freeze_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, if_id_branch, branch_taken,
           id_ex_reg_dst, id_ex_reg_write, id_ex_mem_read, ex_mem_reg_dst, ex_mem_mem_read,
           mem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, stall_active,
           stall_count, freeze_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-in-ID hazard stall controller with memory freeze, taken-branch flush
// and saturating stall/freeze performance counters.
module hazard_stall_controller #(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16,
  parameter bit IGNORE_R0   = 1'b1
) (
  input logic clk,
  input logic rst,
  hazard_stall_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STALL, FREEZE} state_t;

  localparam logic [3:0]       LS_N  = 4'(LOAD_STALLS);
  localparam logic [3:0]       LS_N1 = 4'(LOAD_STALLS + 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [2:0]       remain, remain_nxt;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt;
  logic             match_e, match_m;
  logic             dest_e_valid, dest_m_valid;
  logic [3:0]       need;
  logic             stall, freeze;

  assign dest_e_valid = !(IGNORE_R0 && (bus.id_ex_reg_dst == '0));
  assign dest_m_valid = !(IGNORE_R0 && (bus.ex_mem_reg_dst == '0));

  assign match_e = bus.id_ex_reg_write && dest_e_valid &&
                   ((bus.if_id_uses_rs && (bus.id_ex_reg_dst == bus.if_id_rs)) ||
                    (bus.if_id_uses_rt && (bus.id_ex_reg_dst == bus.if_id_rt)));
  assign match_m = bus.ex_mem_mem_read && dest_m_valid &&
                   ((bus.if_id_uses_rs && (bus.ex_mem_reg_dst == bus.if_id_rs)) ||
                    (bus.if_id_uses_rt && (bus.ex_mem_reg_dst == bus.if_id_rt)));

  // Bubbles needed before the ID instruction may proceed; earlier rules take priority.
  always_comb begin
    need = 4'd0;
    if (bus.if_id_branch && match_e && bus.id_ex_mem_read) begin
      need = LS_N1;
    end else if (bus.if_id_branch && match_e) begin
      need = 4'd1;
    end else if (bus.if_id_branch && match_m) begin
      need = 4'd1;
    end else if (!bus.if_id_branch && match_e && bus.id_ex_mem_read) begin
      need = LS_N;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      remain <= 3'd0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // A freeze-exit cycle already behaves like the state it returns to.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    stall      = 1'b0;
    freeze     = 1'b0;
    if (!bus.mem_ready) begin
      freeze    = 1'b1;
      state_nxt = FREEZE;
    end else if ((state == STALL) || ((state == FREEZE) && (remain != 3'd0))) begin
      stall      = 1'b1;
      remain_nxt = remain - 3'd1;
      state_nxt  = (remain == 3'd1) ? IDLE : STALL;
    end else if (need != 4'd0) begin
      stall      = 1'b1;
      remain_nxt = 3'(need - 4'd1);
      state_nxt  = (need > 4'd1) ? STALL : IDLE;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + ONE;
      end
      if (freeze && (freeze_cnt != '1)) begin
        freeze_cnt <= freeze_cnt + ONE;
      end
    end
  end

  assign bus.pc_write     = !stall && !freeze;
  assign bus.if_id_write  = !stall && !freeze;
  assign bus.id_ex_bubble = stall;
  assign bus.pipe_freeze  = freeze;
  assign bus.if_id_flush  = bus.if_id_branch && bus.branch_taken && !stall && !freeze;
  assign bus.stall_active = (state == STALL) || stall;
  assign bus.stall_count  = stall_cnt;
  assign bus.freeze_count = freeze_cnt;
endmodule
